// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the bit-serial adder sequencer.
package serial_add_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Bit counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
   function automatic int cnt_width(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/fullAdder.sv
// Combinational 1-bit full-adder cell shared by the serial and ripple adders.
module fullAdder (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ c;
   assign co = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one fullAdder cell reused LSB-first over WIDTH clocks.
// Build option: define SERIAL_ADD_SUB_EN to add the sub input (a-b mode).
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic [1:0]       o_dbg_state
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_e             r_state;
   logic [WIDTH-1:0]   r_a_sh;
   logic [WIDTH-1:0]   r_b_sh;
   logic [WIDTH-1:0]   r_sum_sh;
   logic [WIDTH-1:0]   r_sum;
   logic               r_carry;
   logic               r_cout;
   logic [CNT_W-1:0]   r_cnt;

   logic               w_s;
   logic               w_co;
   logic               w_accept;
   logic [WIDTH-1:0]   w_load_b;
   logic               w_load_c;
   logic [WIDTH-1:0]   w_sum_next;

`ifdef SERIAL_ADD_SUB_EN
   // Subtract as a + ~b + 1; the final carry then reads as "no borrow".
   assign w_load_b = sub ? ~b : b;
   assign w_load_c = sub ? 1'b1 : cin;
`else
   assign w_load_b = b;
   assign w_load_c = cin;
`endif

   fullAdder u_cell (
      .a  (r_a_sh[0]),
      .b  (r_b_sh[0]),
      .c  (r_carry),
      .s  (w_s),
      .co (w_co)
   );

   // Handshake: start is honoured only in IDLE or DONE; busy marks RUN,
   // done is high for exactly the single DONE cycle that presents sum/cout.
   assign w_accept   = start && (r_state == IDLE || r_state == DONE);
   assign w_sum_next = {w_s, r_sum_sh[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_a_sh   <= '0;
         r_b_sh   <= '0;
         r_sum_sh <= '0;
         r_sum    <= '0;
         r_carry  <= 1'b0;
         r_cout   <= 1'b0;
         r_cnt    <= '0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (w_accept) begin
                  r_a_sh   <= a;
                  r_b_sh   <= w_load_b;
                  r_carry  <= w_load_c;
                  r_cnt    <= '0;
                  r_sum_sh <= '0;
                  r_state  <= RUN;
               end else begin
                  r_state  <= IDLE;
               end
            end
            RUN: begin
               r_a_sh   <= r_a_sh >> 1;
               r_b_sh   <= r_b_sh >> 1;
               r_sum_sh <= w_sum_next;
               r_carry  <= w_co;
               r_cnt    <= r_cnt + CNT_W'(1);
               if (r_cnt == LAST_CNT) begin
                  r_sum   <= w_sum_next;
                  r_cout  <= w_co;
                  r_state <= DONE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy        = (r_state == RUN);
   assign done        = (r_state == DONE);
   assign sum         = r_sum;
   assign cout        = r_cout;
   assign o_dbg_state = r_state;

endmodule
